multicycle_issue_ctrl: RTL and testbench
========================================

Name: multicycle_issue_ctrl

Overview:
- Issue-side controller for multi-cycle execute ops (integer MUL/DIV, FPU FMUL/FADD/FDIV/FSQRT).
- Accepts one op per handshake and maps its class to a fixed latency.
- Runs an internal down-count and drives pipeline stall plus a done pulse.
- Sits between decode/issue and the EX stage; holds the front of the pipeline until the unit result is valid.

Parameters:
- OP_W, 3, width of op class code
- CNT_W, 5, latency counter width; every latency must be at most 2^CNT_W-1
- LAT_MUL, 2, cycles for integer multiply
- LAT_DIV, 16, cycles for integer divide/remainder
- LAT_FMUL, 3, cycles for FP multiply
- LAT_FADD, 3, cycles for FP add/sub
- LAT_FDIV, 20, cycles for FP divide
- LAT_FSQRT, 24, cycles for FP square root

Ports:
- clk, in, 1, clock
- rstn, in, 1, reset; asynchronous, active-low
- issue_valid, in, 1, op offered this cycle
- issue_op, in, OP_W, op class: 0 MUL, 1 DIV, 2 FMUL, 3 FADD, 4 FDIV, 5 FSQRT, 6-7 reserved
- issue_ready, out, 1, controller can accept an op
- flush, in, 1, synchronous kill of the in-flight op
- stall, out, 1, hold upstream pipeline stages
- busy, out, 1, op in flight (state BUSY)
- done, out, 1, one-cycle pulse; result valid this cycle
- done_op, out, OP_W, class of the op completing; valid when done=1
- stall_cycles, out, 32, present only with MC_PERF_CNT_EN

Behaviour:
- States:
  - IDLE, BUSY.
  - Registers: state, cnt[CNT_W-1:0], op_q[OP_W-1:0].
- Reset (async, rstn=0): state=IDLE, cnt=0, op_q=0.
  - Resulting outputs: issue_ready=1, stall=0, busy=0, done=0, done_op=0.
  - Reset mid-operation abandons the op; no done is produced.
- Latency lookup:
  - LAT(op) is the matching parameter.
  - Reserved codes map to LAT=1.
  - LAT=0 is illegal; elaboration assertion if any parameter is 0 or exceeds 2^CNT_W-1.
- fire = issue_valid & issue_ready & ~flush.
- issue_ready = (state==IDLE) | (state==BUSY & cnt==0).
- done = (state==BUSY) & (cnt==0) & ~flush.
- done_op = op_q when done=1, else 0.
- busy = (state==BUSY).
- stall = fire | (state==BUSY & cnt!=0).
  - stall is combinational from issue_valid, so upstream freezes in the accept cycle.
- Timing for an op accepted in cycle T with latency L:
  - Cycle T+1: cnt=L-1, state=BUSY.
  - Each BUSY cycle with cnt!=0: cnt decrements by 1.
  - done asserted in cycle T+L.
  - stall high in cycles T through T+L-1 and low in T+L.
  - L=1: BUSY only in T+1 with done=1; stall only in T.
- Back-to-back: fire in the done cycle reloads cnt and op_q and stays in BUSY. No idle bubble.
- Done cycle without fire: transition to IDLE.
- issue_valid while BUSY with cnt!=0: not accepted; the requester holds issue_op stable until accepted.
- flush has highest priority after reset:
  - Next state IDLE, cnt=0, and done is suppressed in the flush cycle.
  - Ops offered in the flush cycle are dropped, and stall is 0 from fire.
- cnt never wraps: it decrements only when nonzero.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- Defined:
  - stall_cycles port and a 32-bit counter exist.
  - Counter increments in every cycle with stall=1.
  - It saturates at 32'hFFFF_FFFF, is reset to 0 by rstn, and is unaffected by flush.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package mc_pkg:
  - mc_op_e enum of op classes (OP_W wide).
  - mc_state_e {IDLE, BUSY}.
  - Default latency localparams.
  - CNT_W default.
- Sub-module mc_latency_lut:
  - Combinational, issue_op to LAT-1 as CNT_W bits.
  - Parameterised by the LAT_* values.
  - Reserved codes return 0.

Test Plan:
- Reset, then issue DIV (op=1) at T=5, one cycle valid → issue_ready drops at T=6; stall=1 for T=5..20; done=1 with done_op=1 at T=21 only; busy=0 at T=22.
- Issue MUL at T, then FADD offered continuously from T+1 → FADD accepted at T+2 (done cycle of MUL); FADD done at T+5; exactly two done pulses.
- Reserved op=7 at T → done at T+1; stall only at T.
- FDIV at T, flush at T+4 → busy=0 at T+5; no done pulse for that op; issue_ready=1 at T+5.
- FSQRT at T, rstn pulsed low at T+10 (asynchronous, mid-cycle) → outputs return to reset values immediately; no done afterwards.
- With MC_PERF_CNT_EN: MUL then DIV back-to-back → stall_cycles=18 after both complete; a flush mid-op adds only the cycles stall was actually high.

Source files
------------

// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared types and defaults for the multi-cycle issue controller.
//   mc_op_e    : op class codes (MC_OP_W bits wide; codes 6-7 are reserved)
//   mc_state_e : controller states IDLE / BUSY
//   MC_LAT_*   : default latencies in cycles, one per op class
//   lat_ok()   : range check used at elaboration (1 .. 2^cnt_w-1)
// Optional feature macro used by the controller: MC_PERF_CNT_EN.
// -----------------------------------------------------------------------------
package mc_pkg;

   localparam int MC_OP_W      = 3;
   localparam int MC_CNT_W     = 5;

   localparam int MC_LAT_MUL   = 2;
   localparam int MC_LAT_DIV   = 16;
   localparam int MC_LAT_FMUL  = 3;
   localparam int MC_LAT_FADD  = 3;
   localparam int MC_LAT_FDIV  = 20;
   localparam int MC_LAT_FSQRT = 24;

   typedef enum logic [MC_OP_W-1:0] {
      OP_MUL   = 3'd0,
      OP_DIV   = 3'd1,
      OP_FMUL  = 3'd2,
      OP_FADD  = 3'd3,
      OP_FDIV  = 3'd4,
      OP_FSQRT = 3'd5
   } mc_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mc_state_e;

   // A latency must be at least one cycle and must fit the down-counter.
   function automatic bit lat_ok(input int lat, input int cnt_w);
      return (lat >= 1) && (lat <= (2 ** cnt_w) - 1);
   endfunction

endpackage

// File: rtl/mc_latency_lut.sv
// -----------------------------------------------------------------------------
// mc_latency_lut
// Combinational map from op class to (latency - 1), the value loaded into the
// controller's down-counter on accept. Reserved codes have latency 1 and so
// return 0.
//   i_op      [OP_W-1:0]  : op class code
//   o_lat_m1  [CNT_W-1:0] : latency minus one
// -----------------------------------------------------------------------------
module mc_latency_lut
   import mc_pkg::*;
#(
   parameter int OP_W      = MC_OP_W,
   parameter int CNT_W     = MC_CNT_W,
   parameter int LAT_MUL   = MC_LAT_MUL,
   parameter int LAT_DIV   = MC_LAT_DIV,
   parameter int LAT_FMUL  = MC_LAT_FMUL,
   parameter int LAT_FADD  = MC_LAT_FADD,
   parameter int LAT_FDIV  = MC_LAT_FDIV,
   parameter int LAT_FSQRT = MC_LAT_FSQRT
) (
   input  logic [OP_W-1:0]  i_op,
   output logic [CNT_W-1:0] o_lat_m1
);

   localparam logic [OP_W-1:0] C_MUL   = OP_W'(OP_MUL);
   localparam logic [OP_W-1:0] C_DIV   = OP_W'(OP_DIV);
   localparam logic [OP_W-1:0] C_FMUL  = OP_W'(OP_FMUL);
   localparam logic [OP_W-1:0] C_FADD  = OP_W'(OP_FADD);
   localparam logic [OP_W-1:0] C_FDIV  = OP_W'(OP_FDIV);
   localparam logic [OP_W-1:0] C_FSQRT = OP_W'(OP_FSQRT);

   localparam logic [CNT_W-1:0] M1_MUL   = CNT_W'(LAT_MUL   - 1);
   localparam logic [CNT_W-1:0] M1_DIV   = CNT_W'(LAT_DIV   - 1);
   localparam logic [CNT_W-1:0] M1_FMUL  = CNT_W'(LAT_FMUL  - 1);
   localparam logic [CNT_W-1:0] M1_FADD  = CNT_W'(LAT_FADD  - 1);
   localparam logic [CNT_W-1:0] M1_FDIV  = CNT_W'(LAT_FDIV  - 1);
   localparam logic [CNT_W-1:0] M1_FSQRT = CNT_W'(LAT_FSQRT - 1);

   always_comb begin
      o_lat_m1 = '0;
      case (i_op)
         C_MUL:   o_lat_m1 = M1_MUL;
         C_DIV:   o_lat_m1 = M1_DIV;
         C_FMUL:  o_lat_m1 = M1_FMUL;
         C_FADD:  o_lat_m1 = M1_FADD;
         C_FDIV:  o_lat_m1 = M1_FDIV;
         C_FSQRT: o_lat_m1 = M1_FSQRT;
         default: o_lat_m1 = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_issue_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_issue_ctrl
// Issue-side controller for multi-cycle execute ops (MUL/DIV, FMUL/FADD/FDIV/
// FSQRT). Accepts one op per handshake, counts down its fixed latency, stalls
// the front of the pipeline meanwhile and pulses done when the result is valid.
//
// Handshake: an op is taken in a cycle where issue_valid & issue_ready & ~flush.
// While not taken the requester keeps issue_valid high and issue_op stable.
// issue_ready is also high in the done cycle, so a new op can follow with no
// idle bubble.
//
// Ports:
//   clk, rstn           : clock, asynchronous active-low reset
//   issue_valid/op      : offered op and its class code
//   issue_ready         : controller can accept an op this cycle
//   flush               : synchronous kill of the in-flight op (wins over all)
//   stall               : hold upstream stages (combinational from issue_valid)
//   busy                : op in flight (state BUSY) -- also the FSM state view
//   done, done_op       : one-cycle completion pulse and class of that op
//   stall_cycles [31:0] : saturating count of stall cycles, only when the
//                         MC_PERF_CNT_EN macro is defined
// -----------------------------------------------------------------------------
module multicycle_issue_ctrl
   import mc_pkg::*;
#(
   parameter int OP_W      = MC_OP_W,
   parameter int CNT_W     = MC_CNT_W,
   parameter int LAT_MUL   = MC_LAT_MUL,
   parameter int LAT_DIV   = MC_LAT_DIV,
   parameter int LAT_FMUL  = MC_LAT_FMUL,
   parameter int LAT_FADD  = MC_LAT_FADD,
   parameter int LAT_FDIV  = MC_LAT_FDIV,
   parameter int LAT_FSQRT = MC_LAT_FSQRT
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            issue_valid,
   input  logic [OP_W-1:0] issue_op,
   output logic            issue_ready,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [OP_W-1:0] done_op
`ifdef MC_PERF_CNT_EN
   ,
   output logic [31:0]     stall_cycles
`endif
);

   if (!(lat_ok(LAT_MUL, CNT_W)  && lat_ok(LAT_DIV, CNT_W)  &&
         lat_ok(LAT_FMUL, CNT_W) && lat_ok(LAT_FADD, CNT_W) &&
         lat_ok(LAT_FDIV, CNT_W) && lat_ok(LAT_FSQRT, CNT_W))) begin : g_bad_lat
      $error("multicycle_issue_ctrl: every LAT_* must be in 1 .. 2^CNT_W-1");
   end

   mc_state_e        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [OP_W-1:0]  r_op;

   logic [CNT_W-1:0] w_lat_m1;
   logic             w_busy;
   logic             w_cnt_zero;
   logic             w_fire;

   mc_latency_lut #(
      .OP_W      (OP_W),
      .CNT_W     (CNT_W),
      .LAT_MUL   (LAT_MUL),
      .LAT_DIV   (LAT_DIV),
      .LAT_FMUL  (LAT_FMUL),
      .LAT_FADD  (LAT_FADD),
      .LAT_FDIV  (LAT_FDIV),
      .LAT_FSQRT (LAT_FSQRT)
   ) u_lut (
      .i_op     (issue_op),
      .o_lat_m1 (w_lat_m1)
   );

   assign w_busy     = (r_state == BUSY);
   assign w_cnt_zero = (r_cnt == '0);
   assign w_fire     = issue_valid & issue_ready & ~flush;

   assign issue_ready = ~w_busy | w_cnt_zero;
   assign busy        = w_busy;
   assign done        = w_busy & w_cnt_zero & ~flush;
   assign done_op     = done ? r_op : '0;
   // Combinational from issue_valid so upstream freezes in the accept cycle.
   assign stall       = w_fire | (w_busy & ~w_cnt_zero);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
      end else if (flush) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else if (w_fire) begin
         // Also covers the done cycle: reload and stay BUSY.
         r_state <= BUSY;
         r_cnt   <= w_lat_m1;
         r_op    <= issue_op;
      end else if (w_busy) begin
         if (w_cnt_zero) begin
            r_state <= IDLE;
         end else begin
            r_cnt <= r_cnt - CNT_W'(1);
         end
      end
   end

`ifdef MC_PERF_CNT_EN
   logic [31:0] r_stall_cycles;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_stall_cycles <= '0;
      end else if (stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_multicycle_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_issue_ctrl
// Table-driven per-op latency checks, hand-written back-to-back / flush /
// async-reset sequences, and a done scoreboard keyed on completion cycle.
// Exercises the stall counter when MC_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
module tb_multicycle_issue_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        issue_valid;
   logic [2:0]  issue_op;
   logic        issue_ready;
   logic        flush;
   logic        stall;
   logic        busy;
   logic        done;
   logic [2:0]  done_op;
`ifdef MC_PERF_CNT_EN
   logic [31:0] stall_cycles;
`endif

   multicycle_issue_ctrl dut (
      .clk          (clk),
      .rstn         (rstn),
      .issue_valid  (issue_valid),
      .issue_op     (issue_op),
      .issue_ready  (issue_ready),
      .flush        (flush),
      .stall        (stall),
      .busy         (busy),
      .done         (done),
      .done_op      (done_op)
`ifdef MC_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- counters / check helper ----------------
   int n_vec = 0;
   int n_err = 0;
   int n_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- scoreboard: {done cycle[15:0], op[2:0]} ----------------
   logic [18:0] exp_q[$];

   function automatic int exp_lat(input logic [2:0] op);
      case (op)
         3'd0:    return 2;
         3'd1:    return 16;
         3'd2:    return 3;
         3'd3:    return 3;
         3'd4:    return 20;
         3'd5:    return 24;
         default: return 1;
      endcase
   endfunction

   // Called in the accept cycle (after the posedge that opened it).
   task automatic push(input logic [2:0] op, input int lat);
      logic [15:0] c;
      c = 16'(cyc + lat);
      exp_q.push_back({c, op});
   endtask

   always @(negedge clk) begin
      logic [18:0] e;
      logic [15:0] now;
      now = 16'(cyc);
      if (rstn) begin
         if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
               chk("unexpected_done", {16'd0, done_op}, 32'h0);
               chk("unexpected_done_pulse", done, 0);
            end else begin
               e = exp_q.pop_front();
               chk("done_cycle_op", {now, done_op}, e);
            end
         end else if (exp_q.size() > 0 && exp_q[0][18:3] == now) begin
            chk("missing_done", done, 1);
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [2:0] op;
      int         lat;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs[NV];

`ifdef MC_PERF_CNT_EN
   logic [31:0] base;
`endif
   int done_base;

   initial begin
      vecs[0] = '{3'd1, 16};
      vecs[1] = '{3'd0, 2};
      vecs[2] = '{3'd2, 3};
      vecs[3] = '{3'd3, 3};
      vecs[4] = '{3'd4, 20};
      vecs[5] = '{3'd5, 24};
      vecs[6] = '{3'd6, 1};
      vecs[7] = '{3'd7, 1};
      for (int i = 8; i < NV; i++) begin
         vecs[i].op  = 3'($urandom_range(0, 7));
         vecs[i].lat = exp_lat(vecs[i].op);
      end

      rstn = 1'b0; issue_valid = 1'b0; issue_op = 3'd0; flush = 1'b0;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      chk("rst_ready", issue_ready, 1);
      chk("rst_stall", stall, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_done_op", done_op, 0);
`ifdef MC_PERF_CNT_EN
      chk("rst_stall_cycles", stall_cycles, 0);
`endif
      next_cycle();
      rstn = 1'b1;
      repeat (2) next_cycle();

      // ---- table: single op, full latency profile ----
      for (int i = 0; i < NV; i++) begin
         issue_valid = 1'b1;
         issue_op    = vecs[i].op;
         push(vecs[i].op, vecs[i].lat);
         @(negedge clk);
         chk("accept_stall", stall, 1);
         chk("accept_ready", issue_ready, 1);
         next_cycle();
         issue_valid = 1'b0;
         for (int k = 1; k < vecs[i].lat; k++) begin
            @(negedge clk);
            chk("run_stall", stall, 1);
            chk("run_busy", busy, 1);
            chk("run_ready", issue_ready, 0);
            chk("run_done", done, 0);
            next_cycle();
         end
         @(negedge clk);
         chk("done_pulse", done, 1);
         chk("done_stall", stall, 0);
         chk("done_ready", issue_ready, 1);
         chk("done_busy", busy, 1);
         next_cycle();
         @(negedge clk);
         chk("after_busy", busy, 0);
         chk("after_done", done, 0);
         next_cycle();
      end

      // ---- back-to-back: MUL then FADD held valid from T+1 ----
      done_base   = n_done;
      issue_valid = 1'b1; issue_op = 3'd0; push(3'd0, 2);
      @(negedge clk); chk("b2b_mul_stall", stall, 1);
      next_cycle();
      issue_op = 3'd3;
      @(negedge clk);
      chk("b2b_hold_ready", issue_ready, 0);
      chk("b2b_hold_stall", stall, 1);
      next_cycle();
      push(3'd3, 3);
      @(negedge clk);
      chk("b2b_accept_ready", issue_ready, 1);
      chk("b2b_mul_done", done, 1);
      chk("b2b_accept_stall", stall, 1);
      next_cycle();
      issue_valid = 1'b0;
      repeat (2) begin
         @(negedge clk); chk("b2b_fadd_stall", stall, 1); next_cycle();
      end
      @(negedge clk);
      chk("b2b_fadd_done", done, 1);
      chk("b2b_fadd_done_stall", stall, 0);
      next_cycle();
      @(negedge clk); chk("b2b_idle", busy, 0); next_cycle();
      chk("b2b_two_pulses", n_done - done_base, 2);

      // ---- flush mid FDIV at T+4 ----
      issue_valid = 1'b1; issue_op = 3'd4;
      @(negedge clk); next_cycle();
      issue_valid = 1'b0;
      repeat (3) begin @(negedge clk); next_cycle(); end
      flush = 1'b1;
      @(negedge clk);
      chk("flush_done_suppr", done, 0);
      chk("flush_stall", stall, 1);
      next_cycle();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", busy, 0);
      chk("flush_ready", issue_ready, 1);
      chk("flush_stall_after", stall, 0);
      next_cycle();

      // ---- op offered in a flush cycle is dropped ----
      issue_valid = 1'b1; issue_op = 3'd0; flush = 1'b1;
      @(negedge clk); chk("flush_drop_stall", stall, 0);
      next_cycle();
      issue_valid = 1'b0; flush = 1'b0;
      @(negedge clk); chk("flush_drop_busy", busy, 0);
      next_cycle();

      // ---- flush landing on the done cycle of a MUL ----
      issue_valid = 1'b1; issue_op = 3'd0;
      @(negedge clk); next_cycle();
      issue_valid = 1'b0;
      @(negedge clk); next_cycle();
      flush = 1'b1;
      @(negedge clk);
      chk("flush_on_done", done, 0);
      chk("flush_on_done_op", done_op, 0);
      next_cycle();
      flush = 1'b0;
      @(negedge clk); chk("flush_on_done_busy", busy, 0);
      next_cycle();

      // ---- asynchronous reset mid FSQRT ----
      issue_valid = 1'b1; issue_op = 3'd5;
      @(negedge clk); next_cycle();
      issue_valid = 1'b0;
      repeat (9) begin @(negedge clk); next_cycle(); end
      #2 rstn = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_ready", issue_ready, 1);
      chk("arst_stall", stall, 0);
      chk("arst_done", done, 0);
      chk("arst_done_op", done_op, 0);
`ifdef MC_PERF_CNT_EN
      chk("arst_stall_cycles", stall_cycles, 0);
`endif
      @(negedge clk);
      next_cycle();
      rstn = 1'b1;
      done_base = n_done;
      repeat (30) begin @(negedge clk); next_cycle(); end
      chk("arst_no_done", n_done - done_base, 0);

`ifdef MC_PERF_CNT_EN
      // ---- stall counter: MUL then DIV back-to-back = 2 + 16 ----
      @(negedge clk); base = stall_cycles; next_cycle();
      issue_valid = 1'b1; issue_op = 3'd0; push(3'd0, 2);
      @(negedge clk); next_cycle();
      issue_op = 3'd1;
      @(negedge clk); next_cycle();
      push(3'd1, 16);
      @(negedge clk); next_cycle();
      issue_valid = 1'b0;
      repeat (20) begin @(negedge clk); next_cycle(); end
      @(negedge clk);
      chk("perf_mul_div", stall_cycles - base, 18);
      base = stall_cycles;
      next_cycle();

      // ---- stall counter: FDIV flushed at T+4 adds T..T+4 = 5 ----
      issue_valid = 1'b1; issue_op = 3'd4;
      @(negedge clk); next_cycle();
      issue_valid = 1'b0;
      repeat (3) begin @(negedge clk); next_cycle(); end
      flush = 1'b1;
      @(negedge clk); next_cycle();
      flush = 1'b0;
      repeat (5) begin @(negedge clk); next_cycle(); end
      @(negedge clk);
      chk("perf_flush", stall_cycles - base, 5);
      next_cycle();
`endif

      repeat (3) begin @(negedge clk); next_cycle(); end
      chk("queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
